// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 64/32 restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_e;

  localparam int DW_DEFAULT = 32;
  localparam int CNT_W      = $clog2(DW_DEFAULT);

  // Wide enough for any DW up to 64; users slice off the low DW bits.
  localparam logic [63:0] ERR_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit
// and subtract the divisor when it fits.
module div_step #(
  parameter int DW = 32
) (
  input  logic [DW:0]   r_i,
  input  logic [DW-1:0] divisor_i,
  input  logic          bit_i,
  output logic [DW:0]   r_o,
  output logic          qbit_o
);

  logic [DW+1:0] shifted;

  always_comb begin
    shifted = {r_i, bit_i};
    qbit_o  = (shifted >= {2'b00, divisor_i});
    r_o     = qbit_o ? (DW+1)'(shifted - {2'b00, divisor_i}) : shifted[DW:0];
  end

endmodule

// File: rtl/seq_divider_64by32.sv
// Iterative radix-2 restoring divider, 2*DW / DW -> DW quotient and remainder.
// Define DIVIDER_SIGNED_EN for two's-complement operands with sign fix-up.
module seq_divider_64by32
  import div_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_by_zero,
  output logic            overflow
);

  localparam int CW = $clog2(DW);

  div_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW:0]     rem_q, rem_d;
  logic [DW-1:0]   lo_q, lo_d;
  logic [DW-1:0]   dvs_q, dvs_d;
  logic [DW-1:0]   quot_q, quot_d;
  logic [DW-1:0]   remd_q, remd_d;
  logic            dbz_q, dbz_d;
  logic            ovf_q, ovf_d;

  logic [2*DW-1:0] magDvd;
  logic [DW-1:0]   magDvs;
  logic [DW:0]     stepR;
  logic            stepQ;
  logic [DW-1:0]   qFinal;

`ifdef DIVIDER_SIGNED_EN
  logic            negQ_q, negQ_d;
  logic            negR_q, negR_d;
  logic [DW-1:0]   dvdLo_q, dvdLo_d;

  assign magDvd = dividend[2*DW-1] ? -dividend : dividend;
  assign magDvs = divisor[DW-1] ? -divisor : divisor;
`else
  assign magDvd = dividend;
  assign magDvs = divisor;
`endif

  div_step #(.DW(DW)) uStep (
    .r_i      (rem_q),
    .divisor_i(dvs_q),
    .bit_i    (lo_q[DW-1]),
    .r_o      (stepR),
    .qbit_o   (stepQ)
  );

  // lo_q doubles as the quotient shift register as dividend bits drain out.
  assign qFinal = {lo_q[DW-2:0], stepQ};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    lo_d    = lo_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    remd_d  = remd_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
`ifdef DIVIDER_SIGNED_EN
    negQ_d  = negQ_q;
    negR_d  = negR_q;
    dvdLo_d = dvdLo_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          if (divisor == '0) begin
            dbz_d   = 1'b1;
            quot_d  = ERR_QUOT[DW-1:0];
            remd_d  = dividend[DW-1:0];
            state_d = DONE;
          end else if (magDvd[2*DW-1:DW] >= magDvs) begin
            ovf_d   = 1'b1;
            quot_d  = ERR_QUOT[DW-1:0];
            remd_d  = dividend[DW-1:0];
            state_d = DONE;
          end else begin
            rem_d   = {1'b0, magDvd[2*DW-1:DW]};
            lo_d    = magDvd[DW-1:0];
            dvs_d   = magDvs;
            cnt_d   = CW'(DW-1);
            state_d = CALC;
`ifdef DIVIDER_SIGNED_EN
            negQ_d  = dividend[2*DW-1] ^ divisor[DW-1];
            negR_d  = dividend[2*DW-1];
            dvdLo_d = dividend[DW-1:0];
`endif
          end
        end
      end
      CALC: begin
        rem_d = stepR;
        lo_d  = qFinal;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
`ifdef DIVIDER_SIGNED_EN
          // A negative result may reach -2^(DW-1); a positive one stops one short.
          if (negQ_q ? (qFinal > {1'b1, {(DW-1){1'b0}}}) : qFinal[DW-1]) begin
            ovf_d  = 1'b1;
            quot_d = ERR_QUOT[DW-1:0];
            remd_d = dvdLo_q;
          end else begin
            quot_d = negQ_q ? -qFinal : qFinal;
            remd_d = negR_q ? -stepR[DW-1:0] : stepR[DW-1:0];
          end
`else
          quot_d = qFinal;
          remd_d = stepR[DW-1:0];
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      lo_q    <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      remd_q  <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      negQ_q  <= 1'b0;
      negR_q  <= 1'b0;
      dvdLo_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      lo_q    <= lo_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      remd_q  <= remd_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
`ifdef DIVIDER_SIGNED_EN
      negQ_q  <= negQ_d;
      negR_q  <= negR_d;
      dvdLo_q <= dvdLo_d;
`endif
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = remd_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider_64by32.sv
// Self-checking bench for seq_divider_64by32: directed literal cases plus
// randomized operands scored against an arithmetic reference model.
module tb_seq_divider_64by32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int nCompared = 0;
  int nMismatched = 0;
  int cycleCnt = 0;
  int acceptCycle = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } res_t;

  res_t expQ[$];

  seq_divider_64by32 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    nCompared++;
    if (act !== req) begin
      nMismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain integer division with the error rules layered on top.
  function automatic res_t modelDiv(input logic [63:0] dvd, input logic [31:0] dvs);
    res_t        m;
    logic [63:0] magD;
    logic [31:0] magV;
    logic [63:0] qm;
    logic [63:0] rm;
`ifdef DIVIDER_SIGNED_EN
    logic        neg;
    magD = dvd[63] ? -dvd : dvd;
    magV = dvs[31] ? -dvs : dvs;
    neg  = dvd[63] ^ dvs[31];
`else
    magD = dvd;
    magV = dvs;
`endif
    m.q   = 32'hFFFF_FFFF;
    m.r   = dvd[31:0];
    m.dbz = 1'b0;
    m.ovf = 1'b0;
    m.lat = 1;
    if (dvs == 32'd0) begin
      m.dbz = 1'b1;
    end else if (magD[63:32] >= magV) begin
      m.ovf = 1'b1;
    end else begin
      m.lat = 33;
      qm = magD / {32'd0, magV};
      rm = magD % {32'd0, magV};
`ifdef DIVIDER_SIGNED_EN
      if (neg ? (qm > 64'h8000_0000) : (qm > 64'h7FFF_FFFF)) begin
        m.ovf = 1'b1;
      end else begin
        m.q = neg ? -qm[31:0] : qm[31:0];
        m.r = dvd[63] ? -rm[31:0] : rm[31:0];
      end
`else
      m.q = qm[31:0];
      m.r = rm[31:0];
`endif
    end
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expQ.delete();
    end else begin
      if (out_valid && out_ready && expQ.size() > 0) void'(expQ.pop_front());
      if (in_valid && in_ready) expQ.push_back(modelDiv(dividend, divisor));
    end
  end

  res_t e;
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        e = expQ[0];
        checkOutput("sb_quotient", 64'(quotient), 64'(e.q));
        checkOutput("sb_remainder", 64'(remainder), 64'(e.r));
        checkOutput("sb_div_by_zero", 64'(div_by_zero), 64'(e.dbz));
        checkOutput("sb_overflow", 64'(overflow), 64'(e.ovf));
        checkOutput("sb_in_ready_done", 64'(in_ready), 64'd0);
      end
    end
  end

  // Called #1 after a clock edge; returns #1 after the accept edge.
  task automatic applyStimulus(input logic [63:0] dvd, input logic [31:0] dvs);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 64'(in_ready), 64'd1);
    end else begin
      dividend = dvd;
      divisor  = dvs;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid    = 1'b0;
      acceptCycle = cycleCnt;
    end
  endtask

  task automatic waitResult(output int lat);
    int guard = 0;
    while (!out_valid && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!out_valid) begin
      checkOutput("result_timeout", 64'(out_valid), 64'd1);
      lat = -1;
    end else begin
      lat = cycleCnt - acceptCycle + 1;
    end
  endtask

  task automatic directedOp(input string name, input logic [63:0] dvd, input logic [31:0] dvs,
                            input logic [31:0] qExp, input logic [31:0] rExp,
                            input logic dbzExp, input logic ovfExp, input int latExp);
    int lat;
    applyStimulus(dvd, dvs);
    waitResult(lat);
    checkOutput({name, "_latency"}, 64'(lat), 64'(latExp));
    checkOutput({name, "_quotient"}, 64'(quotient), 64'(qExp));
    checkOutput({name, "_remainder"}, 64'(remainder), 64'(rExp));
    checkOutput({name, "_div_by_zero"}, 64'(div_by_zero), 64'(dbzExp));
    checkOutput({name, "_overflow"}, 64'(overflow), 64'(ovfExp));
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat;
    int          mode;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] dvs;
    res_t        m;

    #12;
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_quotient", 64'(quotient), 64'd0);
    checkOutput("reset_remainder", 64'(remainder), 64'd0);
    checkOutput("reset_div_by_zero", 64'(div_by_zero), 64'd0);
    checkOutput("reset_overflow", 64'(overflow), 64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    directedOp("div100by7", 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33);
`ifndef DIVIDER_SIGNED_EN
    directedOp("roundtrip", 64'h0B00EA4E_242D2080, 32'h9ABCDEF0, 32'h12345678, 32'd0, 1'b0, 1'b0, 33);
    directedOp("max_quot", {32'h6, 32'hFFFF_FFFF}, 32'd7, 32'hFFFF_FFFF, 32'd6, 1'b0, 1'b0, 33);
`else
    directedOp("signed_neg", -64'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, 33);
`endif
    directedOp("divzero", 64'h5, 32'h0, 32'hFFFF_FFFF, 32'h5, 1'b1, 1'b0, 1);
    directedOp("overflow", 64'h1_0000_0000, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1);
    directedOp("ovf_equal", {32'h7, 32'h0000_0003}, 32'h7, 32'hFFFF_FFFF, 32'h3, 1'b0, 1'b1, 1);

    // Held result plus an in_valid pulse that must be ignored mid-calculation.
    out_ready = 1'b0;
    applyStimulus(64'd1000, 32'd33);
    repeat (5) begin @(posedge clk); #1; end
    dividend = 64'd50;
    divisor  = 32'd5;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitResult(lat);
    checkOutput("hold_latency", 64'(lat), 64'd33);
    for (int i = 0; i < 10; i++) begin
      checkOutput("hold_out_valid", 64'(out_valid), 64'd1);
      checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
      checkOutput("hold_quotient", 64'(quotient), 64'd30);
      checkOutput("hold_remainder", 64'(remainder), 64'd10);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_out_valid", 64'(out_valid), 64'd0);
    checkOutput("release_in_ready", 64'(in_ready), 64'd1);

    // Reset in the middle of an iteration.
    applyStimulus(64'h1_2345_6789, 32'h1_0000);
    repeat (15) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset_quotient", 64'(quotient), 64'd0);
    checkOutput("midreset_remainder", 64'(remainder), 64'd0);
    checkOutput("midreset_div_by_zero", 64'(div_by_zero), 64'd0);
    checkOutput("midreset_overflow", 64'(overflow), 64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    directedOp("after_reset", 64'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 33);

    for (int n = 0; n < 60; n++) begin
      mode = int'($urandom_range(0, 9));
      dvs  = $urandom;
      lo   = $urandom;
      if (dvs == 32'd0) dvs = 32'd1;
      case (mode)
        0: begin dvs = 32'd0; hi = $urandom; end
        1: hi = dvs + ($urandom % (32'hFFFF_FFFF - dvs + 32'd1));
        2: begin dvs = $urandom_range(1, 16); hi = $urandom % dvs; end
        3: hi = dvs - 32'd1;
        default: hi = $urandom % dvs;
      endcase
      m = modelDiv({hi, lo}, dvs);
      out_ready = ($urandom_range(0, 3) != 0);
      applyStimulus({hi, lo}, dvs);
      waitResult(lat);
      checkOutput("rand_latency", 64'(lat), 64'(m.lat));
      if (!out_ready) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
